// File: rtl/jts16_colmix_pkg.sv
// ---------------------------------------------------------------------------
// jts16_colmix_pkg
// Shared definitions for the System 16 colour mixer.
//   - bit positions of the per-layer enables in gfx_en
//   - layer priority ranks (lower rank wins)
//   - bit-field offsets inside a 16-bit palette entry
//   - helper that turns a palette entry into 5-bit RGB
// ---------------------------------------------------------------------------
package jts16_colmix_pkg;

    // Position of each layer's enable bit inside gfx_en
    localparam int GFX_FIX  = 0;
    localparam int GFX_SCR1 = 1;
    localparam int GFX_SCR2 = 2;
    localparam int GFX_SPR  = 3;

    // Priority ranks, lowest value wins. A transparent layer takes RANK_NONE
    // so it can never beat the backdrop.
    localparam logic [3:0] RANK_FIX     = 4'd0;
    localparam logic [3:0] RANK_SPR3    = 4'd1;
    localparam logic [3:0] RANK_SCR1_HI = 4'd2;
    localparam logic [3:0] RANK_SCR2_HI = 4'd3;
    localparam logic [3:0] RANK_SPR2    = 4'd4;
    localparam logic [3:0] RANK_SCR1_LO = 4'd5;
    localparam logic [3:0] RANK_SPR1    = 4'd6;
    localparam logic [3:0] RANK_SCR2_LO = 4'd7;
    localparam logic [3:0] RANK_SPR0    = 4'd8;
    localparam logic [3:0] RANK_NONE    = 4'd15;

    // Palette entry layout: three 4-bit colour fields at the bottom and one
    // extra LSB per colour in bits 12..14. Bit 15 carries no colour.
    localparam int PAL_R_FIELD = 0;
    localparam int PAL_G_FIELD = 4;
    localparam int PAL_B_FIELD = 8;
    localparam int PAL_R_LSB   = 12;
    localparam int PAL_G_LSB   = 13;
    localparam int PAL_B_LSB   = 14;

    // Which layer supplied the pixel
    typedef enum logic [2:0] {
        LAYER_BACK,
        LAYER_FIX,
        LAYER_SCR1,
        LAYER_SCR2,
        LAYER_SPR
    } layer_e;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } rgb_t;

    // Sprite priority field to rank
    function automatic logic [3:0] spr_prio_rank(input logic [1:0] prio);
        logic [3:0] rank;
        case (prio)
            2'd3:    rank = RANK_SPR3;
            2'd2:    rank = RANK_SPR2;
            2'd1:    rank = RANK_SPR1;
            default: rank = RANK_SPR0;
        endcase
        return rank;
    endfunction

    // Palette entry (bits 14:0) to 5-bit RGB; the 4-bit field forms the MSBs
    function automatic rgb_t pal_to_rgb(input logic [14:0] e);
        rgb_t c;
        c.r = {e[PAL_R_FIELD +: 4], e[PAL_R_LSB]};
        c.g = {e[PAL_G_FIELD +: 4], e[PAL_G_LSB]};
        c.b = {e[PAL_B_FIELD +: 4], e[PAL_B_LSB]};
        return c;
    endfunction

endpackage

// File: rtl/jts16_pal_ram.sv
// ---------------------------------------------------------------------------
// jts16_pal_ram
// True dual-port 2^AW x 16 palette RAM.
//   Port A (CPU):   a_addr, a_din, a_we[1:0] byte write enables ([1]=upper),
//                   a_re read enable, a_dout registered read data
//   Port B (video): b_addr, b_re read enable, b_dout registered read data
// Port B is read-first: a same-clock write from port A to the same address
// is not visible on b_dout until the following read.
// The read data registers clear on reset; the array contents do not.
// ---------------------------------------------------------------------------
module jts16_pal_ram #(
    parameter int AW = 11
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] a_addr,
    input  logic [15:0]   a_din,
    input  logic [1:0]    a_we,
    input  logic          a_re,
    output logic [15:0]   a_dout,
    input  logic [AW-1:0] b_addr,
    input  logic          b_re,
    output logic [15:0]   b_dout
);

    logic [15:0] mem [0:(1<<AW)-1];

    // CPU byte writes. The array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (a_we[0]) mem[a_addr][7:0]  <= a_din[7:0];
        if (a_we[1]) mem[a_addr][15:8] <= a_din[15:8];
    end

    // CPU read register: keeps the last read value until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dout <= '0;
        end else if (a_re) begin
            a_dout <= mem[a_addr];
        end
    end

    // Video read register. Nonblocking semantics against the write block
    // give read-first behaviour on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_dout <= '0;
        end else if (b_re) begin
            b_dout <= mem[b_addr];
        end
    end

endmodule

// File: rtl/jts16_colmix.sv
// ---------------------------------------------------------------------------
// jts16_colmix
// Colour mixer for the System 16 video path. Each pixel the highest priority
// opaque layer (fix, two scrolls, sprites) is selected, its palette index is
// looked up in the shared palette RAM and the entry is turned into 5-bit RGB.
//   clk, rst_n          system clock, asynchronous active-low reset
//   pxl_cen             pixel clock enable; every video stage advances on it
//   pal_cs, cpu_addr, cpu_dout, dsn, cpu_rnw, cpu_din
//                       CPU palette access (byte writes, registered reads)
//   LHBL, LVBL          active-low blanking in
//   fix_pxl, scr1_pxl, scr2_pxl, spr_pxl, gfx_en
//                       layer pixels and per-layer enables
//   red, green, blue    5-bit colour out
//   LHBL_dly, LVBL_dly  blanking delayed to line up with RGB
// Pixel to RGB latency is two pxl_cen ticks.
// ---------------------------------------------------------------------------
module jts16_colmix
    import jts16_colmix_pkg::*;
#(
    parameter int PALW      = 11,
    parameter bit BLANK_BLK = 1'b1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic        pal_cs,
    input  logic [11:1] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic [1:0]  dsn,
    input  logic        cpu_rnw,
    output logic [15:0] cpu_din,
    input  logic        LHBL,
    input  logic        LVBL,
    input  logic [9:0]  fix_pxl,
    input  logic [10:0] scr1_pxl,
    input  logic [10:0] scr2_pxl,
    input  logic [11:0] spr_pxl,
    input  logic [3:0]  gfx_en,
    output logic [4:0]  red,
    output logic [4:0]  green,
    output logic [4:0]  blue,
    output logic        LHBL_dly,
    output logic        LVBL_dly
);

    logic        fix_op;
    logic        scr1_op;
    logic        scr2_op;
    logic        spr_op;
    logic [3:0]  fix_rank;
    logic [3:0]  scr1_rank;
    logic [3:0]  scr2_rank;
    logic [3:0]  spr_rank;
    logic [3:0]  best_rank;
    layer_e      winner;
    logic [10:0] vid_idx;

    logic        lhbl_s0;
    logic        lvbl_s0;
    logic [15:0] pal_rd;
    rgb_t        pal_rgb;
    logic        cpu_wr;
    logic [1:0]  cpu_we;
    logic        cpu_rd;
    logic        unused_pal_msb;

    // A layer is opaque when its colour field is non-zero and it is enabled.
    // Each opaque layer gets a rank from its own priority bits; transparent
    // layers get RANK_NONE.
    always_comb begin
        fix_op  = (fix_pxl[2:0]  != 3'd0) && gfx_en[GFX_FIX];
        scr1_op = (scr1_pxl[2:0] != 3'd0) && gfx_en[GFX_SCR1];
        scr2_op = (scr2_pxl[2:0] != 3'd0) && gfx_en[GFX_SCR2];
        spr_op  = (spr_pxl[3:0]  != 4'd0) && gfx_en[GFX_SPR];

        fix_rank = fix_op ? RANK_FIX : RANK_NONE;

        scr1_rank = RANK_NONE;
        if (scr1_op) begin
            scr1_rank = scr1_pxl[10] ? RANK_SCR1_HI : RANK_SCR1_LO;
        end

        scr2_rank = RANK_NONE;
        if (scr2_op) begin
            scr2_rank = scr2_pxl[10] ? RANK_SCR2_HI : RANK_SCR2_LO;
        end

        spr_rank = spr_op ? spr_prio_rank(spr_pxl[11:10]) : RANK_NONE;
    end

    // Pick the lowest rank. Opaque ranks are all distinct, so the order of
    // the comparisons does not matter; the backdrop wins when nothing beats
    // RANK_NONE.
    always_comb begin
        winner    = LAYER_BACK;
        best_rank = RANK_NONE;
        if (fix_rank < best_rank) begin
            winner    = LAYER_FIX;
            best_rank = fix_rank;
        end
        if (spr_rank < best_rank) begin
            winner    = LAYER_SPR;
            best_rank = spr_rank;
        end
        if (scr1_rank < best_rank) begin
            winner    = LAYER_SCR1;
            best_rank = scr1_rank;
        end
        if (scr2_rank < best_rank) begin
            winner    = LAYER_SCR2;
            best_rank = scr2_rank;
        end
    end

    // Palette index: tile layers use the lower half of the palette, sprites
    // the upper half. The scroll priority bit is not part of the index.
    always_comb begin
        case (winner)
            LAYER_FIX:  vid_idx = {1'b0, fix_pxl};
            LAYER_SCR1: vid_idx = {1'b0, scr1_pxl[9:0]};
            LAYER_SCR2: vid_idx = {1'b0, scr2_pxl[9:0]};
            LAYER_SPR:  vid_idx = {1'b1, spr_pxl[9:0]};
            default:    vid_idx = 11'd0;
        endcase
    end

    // CPU strobes: dsn bits are active-low byte selects
    always_comb begin
        cpu_wr = pal_cs & ~cpu_rnw;
        cpu_rd = pal_cs & cpu_rnw;
        cpu_we = {2{cpu_wr}} & ~dsn;
    end

    // The RAM's video read register is the first pipeline stage: it captures
    // the mux index on pxl_cen and presents the entry for the next stage.
    jts16_pal_ram #(
        .AW (PALW)
    ) u_pal_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_addr (cpu_addr[PALW:1]),
        .a_din  (cpu_dout),
        .a_we   (cpu_we),
        .a_re   (cpu_rd),
        .a_dout (cpu_din),
        .b_addr (vid_idx[PALW-1:0]),
        .b_re   (pxl_cen),
        .b_dout (pal_rd)
    );

    // Bit 15 of a palette entry has no colour meaning
    assign unused_pal_msb = pal_rd[15];

    always_comb begin
        pal_rgb = pal_to_rgb(pal_rd[14:0]);
    end

    // Blanking travels alongside the palette read, then both land in the
    // output registers on the second tick. Blanked pixels are forced black
    // when BLANK_BLK is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lhbl_s0  <= 1'b0;
            lvbl_s0  <= 1'b0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else if (pxl_cen) begin
            lhbl_s0  <= LHBL;
            lvbl_s0  <= LVBL;
            LHBL_dly <= lhbl_s0;
            LVBL_dly <= lvbl_s0;
            if (BLANK_BLK && !(lhbl_s0 && lvbl_s0)) begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end else begin
                red   <= pal_rgb.r;
                green <= pal_rgb.g;
                blue  <= pal_rgb.b;
            end
        end
    end

endmodule

// File: tb/tb_jts16_colmix.sv
// ---------------------------------------------------------------------------
// tb_jts16_colmix
// Self-checking bench for jts16_colmix: palette loading, priority vectors
// streamed one per pixel, CPU byte writes, read/write collision, blanking
// delay and mid-line reset.
// ---------------------------------------------------------------------------
module tb_jts16_colmix;

    logic        clk;
    logic        rst_n;
    logic        pxl_cen;
    logic        pal_cs;
    logic [11:1] cpu_addr;
    logic [15:0] cpu_dout;
    logic [1:0]  dsn;
    logic        cpu_rnw;
    logic [15:0] cpu_din;
    logic        LHBL;
    logic        LVBL;
    logic [9:0]  fix_pxl;
    logic [10:0] scr1_pxl;
    logic [10:0] scr2_pxl;
    logic [11:0] spr_pxl;
    logic [3:0]  gfx_en;
    logic [4:0]  red;
    logic [4:0]  green;
    logic [4:0]  blue;
    logic        LHBL_dly;
    logic        LVBL_dly;

    int checks = 0;
    int fails  = 0;

    logic [15:0] shadow [0:2047];

    typedef struct {
        string       name;
        logic [9:0]  fix;
        logic [10:0] scr1;
        logic [10:0] scr2;
        logic [11:0] spr;
        logic [3:0]  en;
        logic        hb;
        logic        vb;
        logic [10:0] idx;
    } vec_t;

    typedef struct {
        string       name;
        logic [16:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    jts16_colmix #(
        .PALW      (11),
        .BLANK_BLK (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .pal_cs   (pal_cs),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .dsn      (dsn),
        .cpu_rnw  (cpu_rnw),
        .cpu_din  (cpu_din),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .fix_pxl  (fix_pxl),
        .scr1_pxl (scr1_pxl),
        .scr2_pxl (scr2_pxl),
        .spr_pxl  (spr_pxl),
        .gfx_en   (gfx_en),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly)
    );

    // 100 MHz system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pixel enable on every other rising edge, changed on falling edges
    initial begin
        pxl_cen = 1'b0;
        forever begin
            @(negedge clk);
            pxl_cen = ~pxl_cen;
        end
    end

    // Hard stop in case something stalls
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one value and report a mismatch
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Wait for the next pxl_cen rising edge, then step off the edge
    task automatic waitTick();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (pxl_cen !== 1'b1 && n < 8);
        if (pxl_cen !== 1'b1) begin
            checks++;
            fails++;
            $display("[TB] FAIL pxl_cen tick: none within 8 clocks");
        end
        #1;
    endtask

    // Expected {red,green,blue,LHBL_dly,LVBL_dly} for a palette index
    function automatic logic [16:0] expFor(input logic [10:0] idx, input logic hb, input logic vb);
        logic [15:0] e;
        logic [14:0] c;
        e = shadow[idx];
        c = {e[3:0], e[12], e[7:4], e[13], e[11:8], e[14]};
        if (!(hb && vb)) c = '0;
        return {c, hb, vb};
    endfunction

    function automatic vec_t mk(input string n, input logic [9:0] f, input logic [10:0] s1,
                                input logic [10:0] s2, input logic [11:0] sp, input logic [3:0] en,
                                input logic hb, input logic vb, input logic [10:0] idx);
        vec_t v;
        v.name = n; v.fix = f; v.scr1 = s1; v.scr2 = s2; v.spr = sp;
        v.en = en; v.hb = hb; v.vb = vb; v.idx = idx;
        return v;
    endfunction

    task automatic setVideo(input vec_t v);
        fix_pxl  = v.fix;
        scr1_pxl = v.scr1;
        scr2_pxl = v.scr2;
        spr_pxl  = v.spr;
        gfx_en   = v.en;
        LHBL     = v.hb;
        LVBL     = v.vb;
    endtask

    // Drive one pixel for one tick; the pixel from the previous tick is now
    // at the outputs and is popped from the scoreboard
    task automatic applyStimulus(input vec_t v);
        sb_t e;
        setVideo(v);
        e.name = v.name;
        e.exp  = expFor(v.idx, v.hb, v.vb);
        sb.push_back(e);
        waitTick();
        if (sb.size() > 1) begin
            e = sb.pop_front();
            checkOutput(e.name, {15'd0, red, green, blue, LHBL_dly, LVBL_dly}, {15'd0, e.exp});
        end
    endtask

    task automatic drainPipe();
        sb_t e;
        waitTick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.name, {15'd0, red, green, blue, LHBL_dly, LVBL_dly}, {15'd0, e.exp});
        end
    endtask

    task automatic cpuWrite(input logic [10:0] a, input logic [15:0] d, input logic [1:0] ds);
        pal_cs   = 1'b1;
        cpu_rnw  = 1'b0;
        cpu_addr = a;
        cpu_dout = d;
        dsn      = ds;
        @(posedge clk);
        #1;
        pal_cs  = 1'b0;
        cpu_rnw = 1'b1;
        dsn     = 2'b11;
        if (!ds[0]) shadow[a][7:0]  = d[7:0];
        if (!ds[1]) shadow[a][15:8] = d[15:8];
    endtask

    task automatic cpuRead(input logic [10:0] a, output logic [15:0] d);
        pal_cs   = 1'b1;
        cpu_rnw  = 1'b1;
        cpu_addr = a;
        @(posedge clk);
        #1;
        pal_cs = 1'b0;
        d      = cpu_din;
    endtask

    initial begin
        logic [15:0] rd;
        vec_t scr_only;

        rst_n    = 1'b0;
        pal_cs   = 1'b0;
        cpu_rnw  = 1'b1;
        cpu_addr = '0;
        cpu_dout = '0;
        dsn      = 2'b11;
        LHBL     = 1'b1;
        LVBL     = 1'b1;
        fix_pxl  = '0;
        scr1_pxl = '0;
        scr2_pxl = '0;
        spr_pxl  = '0;
        gfx_en   = 4'hF;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset video outputs", {15'd0, red, green, blue, LHBL_dly, LVBL_dly}, 32'd0);
        checkOutput("reset cpu_din", {16'd0, cpu_din}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the palette with distinct entries; bit 15 toggles to show it is ignored
        for (int a = 0; a < 2048; a++) begin
            logic [10:0] ad;
            logic [15:0] dv;
            ad = 11'(a);
            dv = {ad[0], 15'(a * 7 + 3)};
            if (a == 'h012) dv = 16'h7123;
            cpuWrite(ad, dv, 2'b00);
        end

        // Priority vectors: name, fix, scr1, scr2, spr, gfx_en, LHBL, LVBL, expected index
        vecs.push_back(mk("scr1 only",            10'h0A8, 11'h012, 11'h198, 12'hEA0, 4'hF, 1, 1, 11'h012));
        vecs.push_back(mk("fix over scr1hi spr3", 10'h0A9, 11'h412, 11'h198, 12'hEA7, 4'hF, 1, 1, 11'h0A9));
        vecs.push_back(mk("spr3 over scr1hi",     10'h0A8, 11'h412, 11'h198, 12'hEA7, 4'hF, 1, 1, 11'h6A7));
        vecs.push_back(mk("scr1hi over spr0",     10'h0A8, 11'h412, 11'h198, 12'h2A7, 4'hF, 1, 1, 11'h012));
        vecs.push_back(mk("all transparent",      10'h0A8, 11'h410, 11'h598, 12'hEA0, 4'hF, 1, 1, 11'h000));
        vecs.push_back(mk("all disabled",         10'h0A9, 11'h412, 11'h59D, 12'hEA7, 4'h0, 1, 1, 11'h000));
        vecs.push_back(mk("scr1hi over scr2hi",   10'h0A8, 11'h412, 11'h59D, 12'hAA7, 4'hF, 1, 1, 11'h012));
        vecs.push_back(mk("scr2hi over spr2",     10'h0A8, 11'h410, 11'h59D, 12'hAA7, 4'hF, 1, 1, 11'h19D));
        vecs.push_back(mk("spr2 over scr1lo",     10'h0A8, 11'h012, 11'h19D, 12'hAA7, 4'hF, 1, 1, 11'h6A7));
        vecs.push_back(mk("scr1lo over spr1",     10'h0A8, 11'h012, 11'h19D, 12'h6A7, 4'hF, 1, 1, 11'h012));
        vecs.push_back(mk("spr1 over scr2lo",     10'h0A8, 11'h010, 11'h19D, 12'h6A7, 4'hF, 1, 1, 11'h6A7));
        vecs.push_back(mk("scr2lo over spr0",     10'h0A8, 11'h010, 11'h19D, 12'h2A7, 4'hF, 1, 1, 11'h19D));
        vecs.push_back(mk("spr0 over backdrop",   10'h0A8, 11'h010, 11'h198, 12'h2A7, 4'hF, 1, 1, 11'h6A7));
        vecs.push_back(mk("fix disabled",         10'h0A9, 11'h412, 11'h198, 12'h2A0, 4'hE, 1, 1, 11'h012));
        vecs.push_back(mk("spr disabled",         10'h0A8, 11'h010, 11'h19D, 12'hEA7, 4'h7, 1, 1, 11'h19D));
        vecs.push_back(mk("scr1 disabled",        10'h0A8, 11'h412, 11'h19D, 12'h6A7, 4'hD, 1, 1, 11'h6A7));
        vecs.push_back(mk("hblank one tick",      10'h0A8, 11'h012, 11'h198, 12'hEA0, 4'hF, 0, 1, 11'h012));
        vecs.push_back(mk("vblank one tick",      10'h0A8, 11'h012, 11'h198, 12'hEA0, 4'hF, 1, 0, 11'h012));
        vecs.push_back(mk("fix full width",       10'h3FF, 11'h412, 11'h59D, 12'hEA7, 4'hF, 1, 1, 11'h3FF));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end
        drainPipe();

        // CPU byte writes on address 5
        cpuWrite(11'h005, 16'hABCD, 2'b10);
        cpuRead(11'h005, rd);
        checkOutput("cpu lower byte write", {16'd0, rd}, {16'd0, 16'h80CD});
        cpuWrite(11'h005, 16'h1234, 2'b11);
        cpuRead(11'h005, rd);
        checkOutput("cpu dsn 11 no write", {16'd0, rd}, {16'd0, shadow[11'h005]});
        cpuWrite(11'h005, 16'h5500, 2'b01);
        cpuRead(11'h005, rd);
        checkOutput("cpu upper byte write", {16'd0, rd}, {16'd0, shadow[11'h005]});
        repeat (5) @(posedge clk);
        #1;
        checkOutput("cpu_din holds", {16'd0, cpu_din}, {16'd0, shadow[11'h005]});

        // Collision: CPU writes the displayed entry on the same clock the
        // video port samples it
        scr_only = mk("scr1 only", 10'h0A8, 11'h012, 11'h198, 12'hEA0, 4'hF, 1, 1, 11'h012);
        setVideo(scr_only);
        waitTick();
        waitTick();
        @(posedge clk);
        #1;
        pal_cs   = 1'b1;
        cpu_rnw  = 1'b0;
        cpu_addr = 11'h012;
        cpu_dout = 16'h2A5F;
        dsn      = 2'b00;
        waitTick();
        pal_cs  = 1'b0;
        cpu_rnw = 1'b1;
        dsn     = 2'b11;
        waitTick();
        checkOutput("collision old colour", {17'd0, red, green, blue}, {17'd0, 5'b00111, 5'b00101, 5'b00011});
        shadow[11'h012] = 16'h2A5F;
        waitTick();
        checkOutput("collision new colour", {15'd0, red, green, blue, LHBL_dly, LVBL_dly},
                    {15'd0, expFor(11'h012, 1'b1, 1'b1)});
        cpuRead(11'h012, rd);
        checkOutput("collision cpu readback", {16'd0, rd}, {16'd0, 16'h2A5F});

        // Reset in the middle of a line clears outputs at once
        waitTick();
        checkOutput("pre-reset colour", {15'd0, red, green, blue, LHBL_dly, LVBL_dly},
                    {15'd0, expFor(11'h012, 1'b1, 1'b1)});
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-line reset video", {15'd0, red, green, blue, LHBL_dly, LVBL_dly}, 32'd0);
        checkOutput("mid-line reset cpu_din", {16'd0, cpu_din}, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        waitTick();
        checkOutput("post-reset first tick", {15'd0, red, green, blue, LHBL_dly, LVBL_dly}, 32'd0);
        waitTick();
        checkOutput("post-reset resumed", {15'd0, red, green, blue, LHBL_dly, LVBL_dly},
                    {15'd0, expFor(11'h012, 1'b1, 1'b1)});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
